// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg: shared Wishbone constants and request bundle for the ZAP bus arbiter.
// Exports CTI_* cycle-type codes, wb_req_t (one master's next-cycle request), WB_REQ_RST (idle bus value).
package zap_wb_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_BURST   = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        wen;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [2:0]  cti;
   } wb_req_t;
   localparam wb_req_t WB_REQ_RST = '{cyc: 1'b0, stb: 1'b0, wen: 1'b0, sel: 4'h0,
                                      adr: 32'h0, dat: 32'h0, cti: CTI_EOB};
endpackage

// File: rtl/zap_rr_picker.sv
// zap_rr_picker: picks one requester index, highest-index-wins or round-robin after i_ptr.
// Ports: i_req request vector, i_ptr last granted index, o_idx chosen index, o_valid any request.
module zap_rr_picker #(
   parameter int N  = 3,
   parameter int RR = 0,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   logic [IW-1:0] w_j;
   always_comb begin
      o_idx   = '0;
      o_valid = |i_req;
      w_j     = '0;
      if (RR != 0) begin
         // Descending scan so the nearest slot after i_ptr is the last (winning) assignment.
         for (int i = N; i >= 1; i--) begin
            w_j = IW'((int'(i_ptr) + i) % N);
            if (i_req[w_j]) o_idx = w_j;
         end
      end else begin
         for (int k = 0; k < N; k++) if (i_req[k]) o_idx = IW'(k);
      end
   end
endmodule

// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter: merges NUM_MASTERS Wishbone requesters onto one registered Wishbone B3 port.
// Ports: i_m_* per-master next-cycle requests; o_m_ack/o_m_err responses routed to the granted master;
// o_grant one-hot grant; o_timeout watchdog pulse; o_wb_*_nxt next bus values; o_wb_* registered bus;
// i_wb_ack/i_wb_err bus responses.
module zap_wb_arbiter import zap_wb_pkg::*; #(
   parameter int NUM_MASTERS = 3,
   parameter int ROUND_ROBIN = 0,
   parameter int LOCK_CYC    = 0,
   parameter int TIMEOUT     = 0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [NUM_MASTERS-1:0]   i_m_cyc_nxt,
   input  logic [NUM_MASTERS-1:0]   i_m_stb_nxt,
   input  logic [NUM_MASTERS-1:0]   i_m_wen_nxt,
   input  logic [4*NUM_MASTERS-1:0] i_m_sel_nxt,
   input  logic [32*NUM_MASTERS-1:0] i_m_adr_nxt,
   input  logic [32*NUM_MASTERS-1:0] i_m_dat_nxt,
   input  logic [3*NUM_MASTERS-1:0] i_m_cti_nxt,
   output logic [NUM_MASTERS-1:0]   o_m_ack,
   output logic [NUM_MASTERS-1:0]   o_m_err,
   output logic [NUM_MASTERS-1:0]   o_grant,
   output logic                     o_timeout,
   output logic                     o_wb_cyc_nxt,
   output logic                     o_wb_stb_nxt,
   output logic                     o_wb_wen_nxt,
   output logic [3:0]               o_wb_sel_nxt,
   output logic [31:0]              o_wb_adr_nxt,
   output logic [31:0]              o_wb_dat_nxt,
   output logic [2:0]               o_wb_cti_nxt,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_wen,
   output logic [3:0]               o_wb_sel,
   output logic [31:0]              o_wb_adr,
   output logic [31:0]              o_wb_dat,
   output logic [2:0]               o_wb_cti,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_err
);
   localparam int          IW      = $clog2(NUM_MASTERS);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
   wb_req_t                w_m [NUM_MASTERS];
   wb_req_t                w_nxt, r_bus;
   logic [IW-1:0]          r_grant, r_rr_ptr, w_pick, w_grant_nxt;
   logic [31:0]            r_to_cnt;
   logic [NUM_MASTERS-1:0] w_onehot;
   logic                   w_valid, w_done, w_fire, w_win;
   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_req
      assign w_m[k] = '{cyc: i_m_cyc_nxt[k], stb: i_m_stb_nxt[k], wen: i_m_wen_nxt[k],
                        sel: i_m_sel_nxt[4*k +: 4], adr: i_m_adr_nxt[32*k +: 32],
                        dat: i_m_dat_nxt[32*k +: 32], cti: i_m_cti_nxt[3*k +: 3]};
   end
   zap_rr_picker #(.N(NUM_MASTERS), .RR(ROUND_ROBIN), .IW(IW)) u_pick (
      .i_req   (i_m_cyc_nxt),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick),
      .o_valid (w_valid)
   );
   assign w_done      = r_bus.stb && (i_wb_ack || i_wb_err);
   assign w_fire      = (TIMEOUT != 0) && r_bus.stb && !i_wb_ack && !i_wb_err && (r_to_cnt == TO_LAST);
   // A watchdog expiry always reopens arbitration, even while a locked master still holds cyc.
   assign w_win       = w_fire || ((!r_bus.stb || w_done) && (LOCK_CYC == 0 || !i_m_cyc_nxt[r_grant]));
   assign w_grant_nxt = (w_win && w_valid) ? w_pick : r_grant;
   assign w_onehot    = NUM_MASTERS'(1) << r_grant;
   always_comb begin
      w_nxt     = w_m[w_grant_nxt];
      w_nxt.cyc = w_nxt.cyc && !w_fire;
      w_nxt.stb = w_nxt.stb && !w_fire;
   end
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_bus    <= WB_REQ_RST;
         r_grant  <= '0;
         r_rr_ptr <= IW'(NUM_MASTERS - 1);
         r_to_cnt <= '0;
      end else begin
         r_bus    <= w_nxt;
         r_grant  <= w_grant_nxt;
         if (w_done || w_fire || (w_win && w_valid)) r_rr_ptr <= w_grant_nxt;
         r_to_cnt <= (r_bus.stb && !i_wb_ack && !i_wb_err && !w_fire) ? r_to_cnt + 32'd1 : '0;
      end
   end
   assign o_m_ack      = i_wb_ack ? w_onehot : '0;
   assign o_m_err      = (i_wb_err || w_fire) ? w_onehot : '0;
   assign o_grant      = w_onehot;
   assign o_timeout    = w_fire;
   assign o_wb_cyc_nxt = w_nxt.cyc;
   assign o_wb_stb_nxt = w_nxt.stb;
   assign o_wb_wen_nxt = w_nxt.wen;
   assign o_wb_sel_nxt = w_nxt.sel;
   assign o_wb_adr_nxt = w_nxt.adr;
   assign o_wb_dat_nxt = w_nxt.dat;
   assign o_wb_cti_nxt = w_nxt.cti;
   assign o_wb_cyc     = r_bus.cyc;
   assign o_wb_stb     = r_bus.stb;
   assign o_wb_wen     = r_bus.wen;
   assign o_wb_sel     = r_bus.sel;
   assign o_wb_adr     = r_bus.adr;
   assign o_wb_dat     = r_bus.dat;
   assign o_wb_cti     = r_bus.cti;
endmodule
